// File: rtl/dmem_uart_tx_if.sv
// Data-memory bus seen by the UART transmitter: the core drives address, data and strobes,
// and the responder returns combinational read data and its address-decode hit.
interface dmem_uart_tx_if;
    logic [31:0] ADDRESS;
    logic [31:0] DATA_IN;
    logic        READ;
    logic        WRITE;
    logic [31:0] DATA_OUT;
    logic        HIT;

    modport master (output ADDRESS, DATA_IN, READ, WRITE, input DATA_OUT, HIT);
    modport slave  (input ADDRESS, DATA_IN, READ, WRITE, output DATA_OUT, HIT);
endinterface

// File: rtl/dmem_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's data-memory bus, with a TX FIFO,
// a programmable baud divider and combinational single-cycle reads.
module dmem_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic          CLK,
    input  logic          RESET,
    dmem_uart_tx_if.slave bus,
    output logic          TX
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [15:0]     cyc_q, cyc_d;
    logic [2:0]      bit_q, bit_d;
    logic            tx_q, tx_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            ovf_q;
    logic [15:0]     baud_q;
    logic [15:0]     div_q;
    logic [7:0]      shift_q;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            hit, wr_en, push_req, push, pop, full, empty, bit_end;
    logic [1:0]      sel;
    logic [31:0]     dout;
    logic            unused_bits;

    assign hit      = (bus.ADDRESS[31:4] == BASE_ADDR[31:4]);
    assign sel      = bus.ADDRESS[3:2];
    assign wr_en    = bus.WRITE && hit;
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = (state_q == IDLE) && !empty;
    assign push_req = wr_en && (sel == 2'd0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign push     = push_req && (!full || pop);
    assign bit_end  = (cyc_q == div_q - 16'd1);

    assign bus.HIT      = hit;
    assign bus.DATA_OUT = dout;
    assign TX           = tx_q;
    assign unused_bits  = ^{bus.ADDRESS[1:0], bus.DATA_IN[31:16], BASE_ADDR[3:0]};

    always_comb begin
        dout = 32'h0;
        if (bus.READ && hit) begin
            case (sel)
                2'd1:    dout = {16'h0, 8'(count_q), 4'h0, ovf_q, empty, full, state_q != IDLE};
                2'd2:    dout = {16'h0, baud_q};
                default: dout = 32'h0;
            endcase
        end
    end

    // TX is registered from the current state, so the line lags the FSM by one cycle.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = START;
                    cyc_d   = 16'd0;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d = DATA;
                    cyc_d   = 16'd0;
                    bit_d   = 3'd0;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    cyc_d = 16'd0;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    cyc_d   = 16'd0;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            cyc_q    <= 16'd0;
            bit_q    <= 3'd0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            baud_q   <= DEFAULT_DIV;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (push_req && full && !pop)    ovf_q <= 1'b1;
            else if (wr_en && sel == 2'd1)   ovf_q <= 1'b0;
            if (wr_en && sel == 2'd2)
                baud_q <= (bus.DATA_IN[15:0] == 16'd0) ? 16'd1 : bus.DATA_IN[15:0];
        end
    end

    // Datapath storage carries no reset; the control state above decides when it is valid.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= bus.DATA_IN[7:0];
        if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            div_q   <= baud_q;
        end else if (state_q == DATA && bit_end) begin
            shift_q <= {1'b0, shift_q[7:1]};
        end
    end
endmodule

// File: tb/tb_dmem_uart_tx.sv
// Randomised and directed bench for dmem_uart_tx against a frame-level reference model.
module tb_dmem_uart_tx;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    logic tx;

    dmem_uart_tx_if bus ();

    dmem_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd434)) dut (
        .CLK(clk), .RESET(rst), .bus(bus), .TX(tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a byte queue plus the frame in flight, described by its elapsed cycles.
    logic [7:0]  q[$];
    bit          m_busy = 0;
    int          m_fcyc = 0;
    int          m_fdiv = 1;
    logic [7:0]  m_fbyte = 8'h0;
    bit          m_ovf = 0;
    logic [15:0] m_baud = 16'd434;
    bit          m_tx = 1;
    bit          m_hit, m_pop;
    int          m_slot;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_busy = 0; m_fcyc = 0; m_ovf = 0; m_baud = 16'd434; m_tx = 1;
        end else begin
            m_hit = (bus.ADDRESS[31:4] == BASE[31:4]);
            if (m_busy) begin
                m_slot = m_fcyc / m_fdiv;
                m_tx = (m_slot == 0) ? 1'b0 : (m_slot == 9) ? 1'b1 : m_fbyte[m_slot-1];
            end else begin
                m_tx = 1'b1;
            end
            m_pop = !m_busy && (q.size() != 0);
            if (m_busy) begin
                m_fcyc++;
                if (m_fcyc == 10 * m_fdiv) m_busy = 0;
            end
            if (m_pop) begin
                m_fbyte = q.pop_front();
                m_fdiv = int'(m_baud);
                m_busy = 1;
                m_fcyc = 0;
            end
            if (bus.WRITE && m_hit) begin
                case (bus.ADDRESS[3:2])
                    2'd0: if (q.size() < DEPTH) q.push_back(bus.DATA_IN[7:0]); else m_ovf = 1;
                    2'd1: m_ovf = 0;
                    2'd2: m_baud = (bus.DATA_IN[15:0] == 16'd0) ? 16'd1 : bus.DATA_IN[15:0];
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [31:0] exp_dout();
        logic [31:0] v;
        v = 32'h0;
        if (bus.READ && bus.ADDRESS[31:4] == BASE[31:4]) begin
            case (bus.ADDRESS[3:2])
                2'd1: v = {16'h0, 8'(q.size()), 4'h0, m_ovf, q.size() == 0, q.size() == DEPTH, m_busy};
                2'd2: v = {16'h0, m_baud};
                default: v = 32'h0;
            endcase
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("TX", {31'h0, tx}, {31'h0, m_tx});
        chk("HIT", {31'h0, bus.HIT}, {31'h0, bus.ADDRESS[31:4] == BASE[31:4]});
        chk("DATA_OUT", bus.DATA_OUT, exp_dout());
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.ADDRESS = a; bus.DATA_IN = d; bus.WRITE = 1'b1; bus.READ = 1'b0;
    endtask

    task automatic bus_idle();
        @(negedge clk);
        bus.WRITE = 1'b0; bus.READ = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.ADDRESS = a; bus.READ = 1'b1; bus.WRITE = 1'b0;
        #2 d = bus.DATA_OUT;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_busy || q.size() != 0) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        chk("wait_idle_timeout", {31'h0, m_busy || q.size() != 0}, 32'h0);
        repeat (2) @(posedge clk);
    endtask

    logic [31:0] rv;
    logic [9:0]  frame10;
    int          lows;

    initial begin
        bus.ADDRESS = 32'h0; bus.DATA_IN = 32'h0; bus.READ = 1'b0; bus.WRITE = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        rd(BASE + 32'h4, rv); chk("reset_status", rv, 32'h0000_0004);
        rd(BASE + 32'h8, rv); chk("reset_baud", rv, 32'd434);
        chk("reset_tx", {31'h0, tx}, 32'h1);
        @(negedge clk) bus.ADDRESS = 32'h0000_2000; bus.READ = 1'b1;
        #2 chk("miss_hit", {31'h0, bus.HIT}, 32'h0);
        chk("miss_dout", bus.DATA_OUT, 32'h0);

        // 0x55 at divider 4: TX waveform and BUSY per cycle after the push edge.
        wr(BASE + 32'h8, 32'd4);
        wr(BASE, 32'h0000_0055);
        @(negedge clk) bus.WRITE = 1'b0; bus.ADDRESS = BASE + 32'h4; bus.READ = 1'b1;
        frame10 = {1'b1, 8'h55, 1'b0};
        for (int k = 1; k <= 42; k++) begin
            @(posedge clk); #1;
            if (k == 1 || k == 42) chk("frame55_idle_tx", {31'h0, tx}, 32'h1);
            else                   chk("frame55_tx", {31'h0, tx}, {31'h0, frame10[(k-2)/4]});
            chk("frame55_busy", {31'h0, bus.DATA_OUT[0]}, {31'h0, k <= 40});
        end
        bus_idle();
        wait_idle();

        // Nine back-to-back pushes fill the FIFO; the tenth overflows.
        for (int i = 0; i < 10; i++) wr(BASE, 32'(i));
        bus_idle();
        rd(BASE + 32'h4, rv); chk("ovf_status", rv, 32'h0000_080B);
        wr(BASE + 32'h4, 32'h0);
        bus_idle();
        rd(BASE + 32'h4, rv); chk("ovf_cleared", rv, 32'h0000_0803);
        bus_idle();
        wait_idle();

        // Divider 0 is stored as 1; a 0xFF frame then has a single low cycle.
        wr(BASE + 32'h8, 32'h0);
        bus_idle();
        rd(BASE + 32'h8, rv); chk("baud_zero", rv, 32'd1);
        wr(BASE, 32'h0000_00FF);
        bus_idle();
        lows = 0;
        repeat (15) begin @(posedge clk); #1; if (tx == 1'b0) lows++; end
        chk("div1_low_cycles", 32'(lows), 32'd1);
        wait_idle();

        // Divider change mid-frame applies only to the following frames.
        wr(BASE + 32'h8, 32'd8);
        wr(BASE, 32'h0000_00A5);
        wr(BASE, 32'h0000_003C);
        wr(BASE, 32'h0000_000F);
        bus_idle();
        repeat (20) @(posedge clk);
        wr(BASE + 32'h8, 32'd2);
        bus_idle();
        wait_idle();

        // Reset in the middle of a data bit of an all-zero byte.
        wr(BASE + 32'h8, 32'd8);
        wr(BASE, 32'h0000_0000);
        bus_idle();
        repeat (30) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset_tx", {31'h0, tx}, 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd(BASE + 32'h4, rv); chk("post_reset_status", rv, 32'h0000_0004);
        bus_idle();
        lows = 0;
        repeat (100) begin @(posedge clk); #1; if (tx == 1'b0) lows++; end
        chk("post_reset_quiet", 32'(lows), 32'd0);

        // Random traffic over the whole register window and outside it.
        wr(BASE + 32'h8, 32'd2);
        for (int c = 0; c < 3000; c++) begin
            int r, off;
            logic [31:0] d;
            @(negedge clk);
            r   = $urandom_range(0, 99);
            off = $urandom_range(0, 3);
            bus.ADDRESS = (r < 5) ? $urandom() : BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
            bus.READ    = 1'($urandom_range(0, 1));
            bus.WRITE   = ($urandom_range(0, 99) < 30);
            if (off == 1 && $urandom_range(0, 3) != 0) bus.WRITE = 1'b0;
            d = $urandom();
            if (off == 2) d[15:0] = 16'($urandom_range(0, 3));
            bus.DATA_IN = d;
        end
        bus_idle();
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_uart_tx.md
Name: dmem_uart_tx

Overview:
- Memory-mapped UART transmitter that acts as a responder on the core's data-memory bus: address, write data, READ/WRITE strobes and read-data return.
- Sits beside the data RAM in the top level. The top level routes the bus to this block when HIT is high.
- The core writes bytes into a TX FIFO; the block serialises them 8N1 on TX.
- Reads return data combinationally in the same cycle, because the core is single-cycle.

Parameters:
- BASE_ADDR, 32'h0000_1000, base of the 16-byte register window (bits [3:0] of the value are ignored).
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, 2..64.
- DEFAULT_DIV, 16'd434, reset value of BAUD_DIV (50 MHz / 115200).

Ports:
- CLK  in  1  system clock; single clock domain.
- RESET  in  1  asynchronous, active-high reset.
- ADDRESS  in  32  byte address from core (DIR_DMEM).
- DATA_IN  in  32  write data from core (DATA_WRITE_DMEM).
- READ  in  1  read strobe.
- WRITE  in  1  write strobe.
- DATA_OUT  out  32  read data; combinational.
- HIT  out  1  high when ADDRESS[31:4] == BASE_ADDR[31:4]; combinational.
- TX  out  1  serial output; idles high.

Behaviour:
- Clock, reset and ports:
  - One clock, CLK.
  - Reset is asynchronous, active-high, on port RESET.
- Register map (offset is ADDRESS[3:2], valid only while HIT):
  - 0 TXDATA: write pushes DATA_IN[7:0]; reads return 0.
  - 1 STATUS: bit0 BUSY (frame in progress), bit1 FULL, bit2 EMPTY, bit3 OVF (sticky), bits[15:8] FIFO count; other bits 0. Any write to STATUS clears OVF.
  - 2 BAUD_DIV: R/W, bits[15:0]. A written value of 0 is stored as 1. Reads are zero-extended.
  - 3: reserved. Reads return 0; writes are ignored.
- DATA_OUT:
  - Equals the selected register when READ && HIT, else 32'h0.
  - Reflects pre-clock-edge state.
- Strobes:
  - WRITE acts on the rising CLK edge.
  - If READ and WRITE are both high, the write takes effect and the read returns pre-edge values.
  - Strobes with HIT low have no effect.
- Reset values: TX=1, FIFO empty, count 0, OVF=0, BUSY=0, BAUD_DIV=DEFAULT_DIV, FSM=IDLE. DATA_OUT and HIT are combinational and carry no reset state.
- FIFO:
  - Circular buffer with read/write pointers wrapping modulo FIFO_DEPTH.
  - A push when full, with no simultaneous pop, is dropped and sets OVF.
  - A push and a pop in the same cycle both occur; count is unchanged. This also applies when full.
  - A pop only happens from IDLE when the FIFO is not empty.
- FSM (IDLE, START, DATA, STOP):
  - Bit period = divider cycles, where the divider is BAUD_DIV latched at frame start. A BAUD_DIV write mid-frame affects the next frame only.
  - IDLE: TX=1, BUSY=0. If not EMPTY: pop into an 8-bit shift register, latch the divider, clear the cycle counter, go to START.
  - START: TX=0 for divider cycles, then go to DATA with bit index 0.
  - DATA: TX=shift[0], LSB first. Each bit lasts divider cycles. After bit 7 go to STOP.
  - STOP: TX=1 for divider cycles, then go to IDLE.
  - BUSY=1 in START, DATA and STOP.
  - Back-to-back frames: IDLE lasts exactly 1 cycle between frames when the FIFO is non-empty.
- Latency and frame timing: a push at edge t (FIFO previously empty, FSM idle) is popped at edge t+1. TX falls after edge t+2. A frame lasts 10 × divider cycles.
- TX is driven from a register; it has no combinational path from the bus.
- Reset asserted mid-frame: TX goes to 1 immediately (asynchronously), the FIFO is flushed, and the frame is abandoned.
- Counters:
  - The cycle counter is 16 bits; the bit index is 3 bits.
  - Count width is clog2(FIFO_DEPTH)+1, zero-extended into STATUS[15:8].

Test Plan:
- Reset, then read STATUS and BAUD_DIV -> STATUS=32'h0000_0004, BAUD_DIV=434, TX=1, HIT=0 for address 0x0000_2000.
- Write BAUD_DIV=4, then TXDATA=0x55 -> TX low 4 cycles; then 1,0,1,0,1,0,1,0 for 4 cycles each; then high 4 cycles. Frame is 40 cycles. BUSY=1 throughout and 0 after STOP.
- DIV=4, 9 back-to-back TXDATA writes 0x00..0x08 -> all accepted, count=8, OVF=0. A 10th write is dropped, OVF=1. Bytes 0x00..0x08 are emitted in order with 1 idle cycle between frames. A STATUS write then clears OVF.
- Write BAUD_DIV=0 then read it back -> 1. Transmit 0xFF with DIV=1 -> frame of 10 cycles, TX low for exactly 1 cycle.
- Mid-frame (DIV=8, 3 bytes queued), write BAUD_DIV=2 -> the current frame completes at 80 cycles; the next frame is 20 cycles.
- Assert RESET in the middle of a DATA bit -> TX=1 in the same cycle, STATUS=0x4 after release, and nothing is transmitted afterwards.
